frame_stream_sequencer: RTL and testbench

- Control/sequencing block for the RGB pixel-pair processing datapath.
- Generates VSYNC/HSYNC framing and pixel-pair read addresses (row, col, linear index) with a valid/ready handshake toward the datapath/BMP writer.
- Latches the processing-mode configuration once per frame, so mode changes never take effect mid-frame.
- Sits between the top-level testbench/controller and the image_processing-style datapath, replacing free-running timing with stallable timing.

---
 rtl/frame_stream_sequencer_pkg.sv | 23 ++
 rtl/frame_stream_sequencer_if.sv | 37 +++
 rtl/frame_stream_sequencer_sync_delay_counter.sv | 20 ++
 rtl/frame_stream_sequencer.sv | 112 +++++++++++
 tb/tb_frame_stream_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_stream_sequencer_pkg.sv
// Shared constants for the pixel-pair datapath: sequencer state codes, processing
// modes, beat size, and a width helper.
package image_proc_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_VSYNC = 3'd1;
   localparam logic [2:0] ST_HGAP  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_BRIGHT = 2'd1;
   localparam logic [1:0] MODE_INVERT = 2'd2;
   localparam logic [1:0] MODE_THRESH = 2'd3;

   localparam int PIX_PER_BEAT = 2;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int width_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_stream_sequencer_if.sv
// Control/stream bundle between the frame controller (master) and the
// frame_stream_sequencer (slave).
interface frame_stream_sequencer_if #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int COL_W  = image_proc_pkg::width_min1(WIDTH),
   parameter int ROW_W  = image_proc_pkg::width_min1(HEIGHT),
   parameter int ADDR_W = image_proc_pkg::width_min1(WIDTH*HEIGHT)
);
   logic              start;
   logic              abort;
   logic [1:0]        mode_in;
   logic [7:0]        param_in;
   logic              pix_ready;
   logic              pix_valid;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic [ADDR_W-1:0] pix_addr;
   logic              VSYNC;
   logic              HSYNC;
   logic [1:0]        mode_out;
   logic [7:0]        param_out;
   logic              busy;
   logic              frame_done;

   modport master (
      output start, abort, mode_in, param_in, pix_ready,
      input  pix_valid, row, col, pix_addr, VSYNC, HSYNC,
             mode_out, param_out, busy, frame_done
   );

   modport slave (
      input  start, abort, mode_in, param_in, pix_ready,
      output pix_valid, row, col, pix_addr, VSYNC, HSYNC,
             mode_out, param_out, busy, frame_done
   );
endinterface

// File: rtl/frame_stream_sequencer_sync_delay_counter.sv
// Loadable down-counter that parks at zero; tc flags the terminal (zero) count.
module sync_delay_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 cnt <= '0;
      else if (load)           cnt <= load_val;
      else if (cnt != '0)      cnt <= cnt - W'(1);
   end

   assign tc = (cnt == '0);
endmodule

// File: rtl/frame_stream_sequencer.sv
// Stallable frame timing: VSYNC phase, per-line blanking, and pixel-pair addressing
// with valid/ready. Define CONTINUOUS_FRAME_EN to loop frames until abort.
module frame_stream_sequencer
   import image_proc_pkg::*;
#(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int START_UP_DELAY = 100,
   parameter int HSYNC_DELAY    = 160,
   parameter int COL_W          = width_min1(WIDTH),
   parameter int ROW_W          = width_min1(HEIGHT),
   parameter int ADDR_W         = width_min1(WIDTH*HEIGHT)
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   frame_stream_sequencer_if.slave  bus
);
   localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
   localparam int CNT_W   = width_min1(DLY_MAX);

`ifdef CONTINUOUS_FRAME_EN
   localparam logic [2:0] DONE_NXT = ST_VSYNC;
`else
   localparam logic [2:0] DONE_NXT = ST_IDLE;
`endif

   logic [2:0]        state, nxt;
   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        mode_q;
   logic [7:0]        param_q;
   logic              dly_tc, dly_load, last_col, last_row, xfer, latch_cfg, clr_pos;
   logic [CNT_W-1:0]  dly_val;

   assign last_col = (col_q == COL_W'(WIDTH-2));
   assign last_row = (row_q == ROW_W'(HEIGHT-1));
   assign xfer     = (state == ST_DATA) && bus.pix_ready;

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (bus.start) nxt = ST_VSYNC;
         ST_VSYNC: if (dly_tc)    nxt = ST_HGAP;
         ST_HGAP:  if (dly_tc)    nxt = ST_DATA;
         ST_DATA:  if (xfer && last_col) nxt = last_row ? ST_DONE : ST_HGAP;
         ST_DONE:  nxt = DONE_NXT;
         default:  nxt = ST_IDLE;
      endcase
      if (bus.abort) nxt = ST_IDLE;
   end

   // Every state change reloads the shared delay counter; timed phases load N-1
   // so tc marks their last cycle.
   assign dly_load = (nxt != state);
   assign dly_val  = (nxt == ST_VSYNC) ? CNT_W'(START_UP_DELAY-1) :
                     (nxt == ST_HGAP)  ? CNT_W'(HSYNC_DELAY-1)    : '0;

   // Config is captured only on entry to VSYNC, so it is stable across a frame.
   assign latch_cfg = (nxt == ST_VSYNC) && (state != ST_VSYNC);
   assign clr_pos   = bus.abort || (state == ST_IDLE) || (state == ST_DONE);

   sync_delay_counter #(.W(CNT_W)) u_dly (
      .clk      (HCLK),
      .rst      (HRESET),
      .load     (dly_load),
      .load_val (dly_val),
      .tc       (dly_tc)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state   <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         mode_q  <= '0;
         param_q <= '0;
      end else begin
         state <= nxt;
         if (latch_cfg) begin
            mode_q  <= bus.mode_in;
            param_q <= bus.param_in;
         end
         if (clr_pos) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
         end else if (xfer) begin
            if (!last_col) begin
               col_q  <= col_q + COL_W'(PIX_PER_BEAT);
               addr_q <= addr_q + ADDR_W'(PIX_PER_BEAT);
            end else if (!last_row) begin
               col_q  <= '0;
               row_q  <= row_q + ROW_W'(1);
               addr_q <= addr_q + ADDR_W'(PIX_PER_BEAT);
            end
         end
      end
   end

   assign bus.pix_valid  = (state == ST_DATA);
   assign bus.HSYNC      = (state == ST_DATA);
   assign bus.VSYNC      = (state == ST_VSYNC);
   assign bus.busy       = (state != ST_IDLE);
   assign bus.frame_done = (state == ST_DONE);
   assign bus.row        = row_q;
   assign bus.col        = col_q;
   assign bus.pix_addr   = addr_q;
   assign bus.mode_out   = mode_q;
   assign bus.param_out  = param_q;
endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Bench for frame_stream_sequencer on an 8x4 frame: checkpoint table, directed
// corner sequences, and random stimulus against a beat-count reference model.
module tb_frame_stream_sequencer;
   import image_proc_pkg::*;

   localparam int W = 8, H = 4, SUD = 3, HSD = 2;
   localparam int COL_W = width_min1(W), ROW_W = width_min1(H), ADDR_W = width_min1(W*H);
   localparam int BPL = W/2, TOT = BPL*H;
`ifdef CONTINUOUS_FRAME_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   typedef struct packed {
      logic vs, hs, pv, busy, done;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        mode;
      logic [7:0]        param;
   } obs_t;

   typedef struct {
      int   cyc;
      logic rdy;
      obs_t exp;
   } vec_t;

   typedef enum {P_IDLE, P_VS, P_GAP, P_DAT, P_DONE} ph_t;

   logic HCLK = 1'b0;
   logic HRESET = 1'b1;
   int   n_vec = 0, n_err = 0;

   frame_stream_sequencer_if #(.WIDTH(W), .HEIGHT(H)) bus ();

   frame_stream_sequencer #(
      .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD)
   ) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus.slave)
   );

   always #5 HCLK = ~HCLK;

   function automatic obs_t mk(input bit vs, hs, pv, bz, dn, input int r, c, a, md, pm);
      obs_t o;
      o.vs = vs; o.hs = hs; o.pv = pv; o.busy = bz; o.done = dn;
      o.row = ROW_W'(r); o.col = COL_W'(c); o.addr = ADDR_W'(a);
      o.mode = 2'(md); o.param = 8'(pm);
      return o;
   endfunction

   function automatic obs_t sample();
      return mk(bus.VSYNC, bus.HSYNC, bus.pix_valid, bus.busy, bus.frame_done,
                int'(bus.row), int'(bus.col), int'(bus.pix_addr),
                int'(bus.mode_out), int'(bus.param_out));
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("vs%b hs%b pv%b busy%b done%b row%0d col%0d addr%0d mode%0d param%0d",
                       o.vs, o.hs, o.pv, o.busy, o.done, o.row, o.col, o.addr, o.mode, o.param);
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: phase plus beats transferred this frame; position is derived
   // arithmetically from the beat count.
   ph_t        m_ph;
   int         m_left, m_beats;
   logic [1:0] m_mode;
   logic [7:0] m_param;

   function automatic obs_t model_obs();
      return mk(m_ph == P_VS, m_ph == P_DAT, m_ph == P_DAT, m_ph != P_IDLE, m_ph == P_DONE,
                m_beats / BPL, 2 * (m_beats % BPL), 2 * m_beats, int'(m_mode), int'(m_param));
   endfunction

   task automatic model_step(input logic st, ab, rdy, input logic [1:0] mi, input logic [7:0] pi);
      if (ab) begin
         m_ph = P_IDLE; m_beats = 0;
      end else begin
         case (m_ph)
            P_IDLE: if (st) begin
               m_ph = P_VS; m_left = SUD; m_mode = mi; m_param = pi;
            end
            P_VS: begin
               m_left--;
               if (m_left == 0) begin m_ph = P_GAP; m_left = HSD; end
            end
            P_GAP: begin
               m_left--;
               if (m_left == 0) m_ph = P_DAT;
            end
            P_DAT: if (rdy) begin
               if (m_beats + 1 == TOT) m_ph = P_DONE;
               else begin
                  m_beats++;
                  if (m_beats % BPL == 0) begin m_ph = P_GAP; m_left = HSD; end
               end
            end
            P_DONE: begin
               m_beats = 0;
               if (CONT) begin
                  m_ph = P_VS; m_left = SUD; m_mode = mi; m_param = pi;
               end else m_ph = P_IDLE;
            end
            default: m_ph = P_IDLE;
         endcase
      end
   endtask

   // Start pulse issued at a negedge; on return the caller sits at cycle 1.
   task automatic kick(input logic [1:0] md, input logic [7:0] pm);
      @(negedge HCLK);
      bus.start = 1'b1; bus.mode_in = md; bus.param_in = pm;
      @(negedge HCLK);
      bus.start = 1'b0;
   endtask

   task automatic stop_frame();
      @(negedge HCLK); bus.abort = 1'b1;
      @(negedge HCLK); bus.abort = 1'b0;
   endtask

   vec_t tbl[11];

   initial begin
      obs_t o, prev;
      int   c, xfers, stalls, done_cyc, hold_err, seq_err, seen, d1, d2, busy_after, vs29;
      bit   tog, prev_stall, found;

      bus.start = 0; bus.abort = 0; bus.mode_in = 0; bus.param_in = 0; bus.pix_ready = 1;

      tbl[0]  = '{1,  1'b1, mk(1,0,0,1,0, 0,0,0,  3,90)};
      tbl[1]  = '{3,  1'b1, mk(1,0,0,1,0, 0,0,0,  3,90)};
      tbl[2]  = '{4,  1'b1, mk(0,0,0,1,0, 0,0,0,  3,90)};
      tbl[3]  = '{5,  1'b1, mk(0,0,0,1,0, 0,0,0,  3,90)};
      tbl[4]  = '{6,  1'b1, mk(0,1,1,1,0, 0,0,0,  3,90)};
      tbl[5]  = '{9,  1'b1, mk(0,1,1,1,0, 0,6,6,  3,90)};
      tbl[6]  = '{10, 1'b1, mk(0,0,0,1,0, 1,0,8,  3,90)};
      tbl[7]  = '{12, 1'b1, mk(0,1,1,1,0, 1,0,8,  3,90)};
      tbl[8]  = '{27, 1'b1, mk(0,1,1,1,0, 3,6,30, 3,90)};
      tbl[9]  = '{28, 1'b1, mk(0,0,0,1,1, 3,6,30, 3,90)};
`ifdef CONTINUOUS_FRAME_EN
      tbl[10] = '{29, 1'b1, mk(1,0,0,1,0, 0,0,0,  1,90)};
`else
      tbl[10] = '{29, 1'b1, mk(0,0,0,0,0, 0,0,0,  3,90)};
`endif

      // Reset state
      @(negedge HCLK);
      check("reset_state", sample(), mk(0,0,0,0,0, 0,0,0, 0,0));
      HRESET = 1'b0;

      // abort+start together in IDLE: nothing happens, config not latched
      @(negedge HCLK);
      bus.start = 1; bus.abort = 1; bus.mode_in = MODE_THRESH; bus.param_in = 8'd55;
      @(negedge HCLK);
      bus.start = 0; bus.abort = 0;
      check("start_abort_idle", sample(), mk(0,0,0,0,0, 0,0,0, 0,0));

      // Nominal frame checkpoints; mode_in changes mid-frame must not leak through
      kick(MODE_THRESH, 8'd90);
      for (c = 1; c <= 29; c++) begin
         if (c > 1) @(negedge HCLK);
         for (int i = 0; i < 11; i++)
            if (tbl[i].cyc == c) begin
               check($sformatf("nominal_c%0d", c), sample(), tbl[i].exp);
               bus.pix_ready = tbl[i].rdy;
            end
         if (c == 1) bus.mode_in = MODE_BRIGHT;
      end
      stop_frame();

      // Backpressure: ready alternates during DATA
      xfers = 0; stalls = 0; done_cyc = -1; hold_err = 0; seq_err = 0;
      tog = 1; prev_stall = 0; prev = '0;
      kick(MODE_BYPASS, 8'd0);
      for (c = 1; c <= 200; c++) begin
         if (c > 1) @(negedge HCLK);
         o = sample();
         if (prev_stall && (o.row != prev.row || o.col != prev.col || o.addr != prev.addr))
            hold_err++;
         if (o.done) begin done_cyc = c; break; end
         if (o.pv) begin
            bus.pix_ready = tog; tog = !tog;
            if (bus.pix_ready) begin
               if (int'(o.addr) != 2 * xfers) seq_err++;
               xfers++;
            end else stalls++;
            prev_stall = !bus.pix_ready;
            prev = o;
         end else prev_stall = 0;
      end
      check_int("bp_transfers", xfers, 16);
      check_int("bp_done_cycle", done_cyc, 28 + stalls);
      check_int("bp_hold_errors", hold_err, 0);
      check_int("bp_addr_seq_errors", seq_err, 0);
      bus.pix_ready = 1;
      stop_frame();

      // Abort mid-line at row 1, col 4 together with a transfer
      found = 0;
      kick(MODE_INVERT, 8'd7);
      for (c = 1; c <= 100; c++) begin
         if (c > 1) @(negedge HCLK);
         o = sample();
         if (o.pv && o.row == 1 && o.col == 4) begin
            bus.abort = 1; found = 1; break;
         end
      end
      check_int("abort_reached", int'(found), 1);
      @(negedge HCLK);
      bus.abort = 0;
      check("abort_idle", sample(), mk(0,0,0,0,0, 0,0,0, 2,7));
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge HCLK);
         if (bus.frame_done || bus.busy) seen++;
      end
      check_int("abort_no_activity", seen, 0);
      kick(MODE_INVERT, 8'd7);
      for (c = 1; c <= 50; c++) begin
         if (c > 1) @(negedge HCLK);
         if (bus.pix_valid) break;
      end
      check_int("restart_latency", c, 6);
      check("restart_addr", sample(), mk(0,1,1,1,0, 0,0,0, 2,7));
      stop_frame();

      // Async reset during DATA
      kick(MODE_THRESH, 8'd200);
      for (c = 1; c <= 50 && !bus.pix_valid; c++) @(negedge HCLK);
      @(negedge HCLK);
      HRESET = 1;
      #1;
      check("reset_async", sample(), mk(0,0,0,0,0, 0,0,0, 0,0));
      @(negedge HCLK);
      HRESET = 0;

      // Start while busy is ignored
      d1 = -1; d2 = -1; busy_after = 0; vs29 = 0;
      kick(MODE_BYPASS, 8'd1);
      for (c = 1; c <= 60; c++) begin
         if (c > 1) @(negedge HCLK);
         if (bus.frame_done) begin
            if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
         end
         if (c > 28 && bus.busy) busy_after++;
         if (c == 29) vs29 = int'(bus.VSYNC);
         bus.start = (c == 5);
      end
      bus.start = 0;
      check_int("busy_start_done_cycle", d1, 28);
`ifdef CONTINUOUS_FRAME_EN
      check_int("cont_second_done", d2, 56);
      check_int("cont_vsync_after_done", vs29, 1);
`else
      check_int("busy_start_not_queued", busy_after, 0);
      check_int("single_frame_done", d2, -1);
`endif
      stop_frame();

      // Random stimulus against the reference model
      @(negedge HCLK);
      HRESET = 1;
      bus.start = 0; bus.abort = 0; bus.pix_ready = 0;
      @(negedge HCLK);
      HRESET = 0;
      m_ph = P_IDLE; m_left = 0; m_beats = 0; m_mode = 0; m_param = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge HCLK);
         check("random", sample(), model_obs());
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.abort     = ($urandom_range(0, 99) == 0);
         bus.pix_ready = ($urandom_range(0, 3) != 0);
         bus.mode_in   = 2'($urandom_range(0, 3));
         bus.param_in  = 8'($urandom_range(0, 255));
         model_step(bus.start, bus.abort, bus.pix_ready, bus.mode_in, bus.param_in);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
